// File: rtl/packer_write_arbiter_if.sv
// Bundle between producer lanes, the write arbiter and the packer write port.
// slave: the arbiter's view. master: the surrounding producers/packer.
interface packer_write_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IN_WIDTH = 64
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          s_write_req;
  logic [NUM_REQ-1:0]          s_write_ready;
  logic [NUM_REQ*IN_WIDTH-1:0] s_write_data;
  logic                        m_write_req;
  logic                        m_write_ready;
  logic [IN_WIDTH-1:0]         m_write_data;
  logic [ID_W-1:0]             m_owner;
  logic                        m_busy;
  logic                        m_group_last;

  modport slave (
    input  s_write_req, s_write_data, m_write_ready,
    output s_write_ready, m_write_req, m_write_data, m_owner, m_busy, m_group_last
  );

  modport master (
    output s_write_req, s_write_data, m_write_ready,
    input  s_write_ready, m_write_req, m_write_data, m_owner, m_busy, m_group_last
  );
endinterface

// File: rtl/packer_write_arbiter.sv
// Round-robin arbiter sharing one packer write port among NUM_REQ streams.
// A grant is held for exactly PACK_RATIO accepted beats so every packed word
// carries beats from a single requester.
module packer_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned IN_WIDTH   = 64,
  parameter int unsigned PACK_RATIO = 2
) (
  input logic                    clk,
  input logic                    reset,
  packer_write_arbiter_if.slave  arb_io
);
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(PACK_RATIO - 1);
  localparam logic [ID_W-1:0]  LastId   = ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic                busy;
  logic                m_req;
  logic                acc;
  logic [ID_W-1:0]     owner_inc;
  logic [NUM_REQ-1:0]  s_ready;
  logic [IN_WIDTH-1:0] m_data;

  // First requester at or after start, wrapping; returns start if none.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    start);
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx_id;
    logic            found;
    int unsigned     idx;
    win   = start;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx    = (32'(start) + k) % NUM_REQ;
      idx_id = ID_W'(idx);
      if (!found && req[idx_id]) begin
        win   = idx_id;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Datapath and handshake outputs, all decoded from the current owner.
  always_comb begin
    busy      = (state_q == StBusy);
    m_req     = busy & arb_io.s_write_req[owner_q];
    m_data    = arb_io.s_write_data[32'(owner_q) * IN_WIDTH +: IN_WIDTH];
    acc       = m_req & arb_io.m_write_ready;
    owner_inc = (owner_q == LastId) ? '0 : owner_q + 1'b1;
    s_ready   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      s_ready[i] = busy && (owner_q == ID_W'(i)) && arb_io.m_write_ready;
    end
  end

  assign arb_io.m_write_req   = m_req;
  assign arb_io.m_write_data  = m_data;
  assign arb_io.s_write_ready = s_ready;
  assign arb_io.m_owner       = owner_q;
  assign arb_io.m_busy        = busy;
  assign arb_io.m_group_last  = busy && (beat_cnt_q == LastBeat);

  // Next-state: grant on idle, count beats, hand off at the group boundary.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (|arb_io.s_write_req) begin
          owner_d    = rr_pick(arb_io.s_write_req, rr_ptr_q);
          beat_cnt_d = '0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (acc) begin
          if (beat_cnt_q == LastBeat) begin
            beat_cnt_d = '0;
            rr_ptr_d   = owner_inc;
            // Zero-bubble handoff: requests of this same cycle pick the next owner.
            if (|arb_io.s_write_req) begin
              owner_d = rr_pick(arb_io.s_write_req, owner_inc);
            end else begin
              state_d = StIdle;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; synchronous reset drops any partial group.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_packer_write_arbiter.sv
// Scoreboard bench: a grant-level reference model predicts every accepted beat
// (cycle, owner, data, group-last); monitors pop and compare on each DUT accept.
module tb_packer_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int PR = 2;
  localparam int N2 = 3;
  localparam int W2 = 8;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  always #5 clk = ~clk;

  packer_write_arbiter_if #(.NUM_REQ(N),  .IN_WIDTH(W))  bus  ();
  packer_write_arbiter_if #(.NUM_REQ(N2), .IN_WIDTH(W2)) bus2 ();

  packer_write_arbiter #(.NUM_REQ(N), .IN_WIDTH(W), .PACK_RATIO(PR)) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_io (bus)
  );

  packer_write_arbiter #(.NUM_REQ(N2), .IN_WIDTH(W2), .PACK_RATIO(1)) dut2 (
    .clk    (clk),
    .reset  (reset2),
    .arb_io (bus2)
  );

  typedef struct {
    int          cyc;
    int          owner;
    logic [63:0] data;
    logic        last;
  } beat_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  beat_t       exp_q[$];
  int          exp2_q[$];
  logic [63:0] pq[N][$];
  int          cyc = 0;
  // Reference model: who holds the grant, beats done in the group, rotation start.
  int          m_holder = -1;
  int          m_done   = 0;
  int          m_ptr    = 0;
  logic [N-1:0] en_off  = '0;
  bit          ready_low = 1'b0;
  int          en_pct   = 100;
  int          rdy_pct  = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: cycle budget exhausted", name);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive producers and packer ready, advance the reference model.
  task automatic step(input bit rst);
    logic [N-1:0]   req;
    logic [N*W-1:0] dat;
    logic           rdy;
    beat_t          b;
    @(posedge clk);
    #1;
    cyc++;
    req = '0;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        dat[i*W +: W] = pq[i][0];
        if (!en_off[i] && ($urandom_range(99) < en_pct)) req[i] = 1'b1;
      end else begin
        dat[i*W +: W] = {$urandom, $urandom};
      end
    end
    rdy = !ready_low && ($urandom_range(99) < rdy_pct);
    if (rst) begin
      req = '0;
      rdy = 1'b0;
    end
    reset             = rst;
    bus.s_write_req   = req;
    bus.s_write_data  = dat;
    bus.m_write_ready = rdy;
    if (rst) begin
      m_holder = -1;
      m_done   = 0;
      m_ptr    = 0;
      for (int i = 0; i < N; i++) pq[i].delete();
    end else if (m_holder < 0) begin
      if (|req) begin
        m_holder = pick(req, m_ptr);
        m_done   = 0;
      end
    end else if (req[m_holder] && rdy) begin
      b.cyc   = cyc;
      b.owner = m_holder;
      b.data  = pq[m_holder].pop_front();
      b.last  = (m_done == PR - 1);
      exp_q.push_back(b);
      m_done++;
      if (m_done == PR) begin
        m_done   = 0;
        m_ptr    = (m_holder + 1) % N;
        m_holder = (|req) ? pick(req, m_ptr) : -1;
      end
    end
  endtask

  task automatic load(input int p, input int nbeats);
    for (int k = 0; k < nbeats; k++) pq[p].push_back({$urandom, $urandom});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name, input int maxc);
    int k;
    k = 0;
    while (!all_empty() && k < maxc) begin
      step(1'b0);
      k++;
    end
    if (k == maxc) bound_fail(name);
    step(1'b0);
    step(1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    check({name, "_busy"},  64'(bus.m_busy), 64'd0);
    check({name, "_mreq"},  64'(bus.m_write_req), 64'd0);
    check({name, "_sready"}, 64'(bus.s_write_ready), 64'd0);
    check({name, "_last"},  64'(bus.m_group_last), 64'd0);
    check({name, "_owner"}, 64'(bus.m_owner), 64'd0);
  endtask

  // Monitor for the main instance.
  beat_t        mb;
  logic [N-1:0] moh;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.m_write_req === 1'b1 && bus.m_write_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: owner %0d data %0h, expected none (cycle %0d)",
                   bus.m_owner, bus.m_write_data, cyc);
        end else begin
          mb  = exp_q.pop_front();
          moh = '0;
          moh[mb.owner] = 1'b1;
          check("beat_cycle", 64'(cyc), 64'(mb.cyc));
          check("beat_owner", 64'(bus.m_owner), 64'(mb.owner));
          check("beat_data",  bus.m_write_data, mb.data);
          check("beat_last",  64'(bus.m_group_last), 64'(mb.last));
          check("beat_sready", 64'(bus.s_write_ready), 64'(moh));
        end
      end
    end
  end

  // Monitor for the 3-requester, one-beat-per-group instance.
  int m2;
  initial begin
    forever begin
      @(negedge clk);
      if (bus2.m_write_req === 1'b1 && bus2.m_write_ready === 1'b1) begin
        if (exp2_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat2: owner %0d, expected none", bus2.m_owner);
        end else begin
          m2 = exp2_q.pop_front();
          check("rr3_owner", 64'(bus2.m_owner), 64'(m2));
          check("rr3_data",  64'(bus2.m_write_data), 64'(m2 * 17));
          check("rr3_last",  64'(bus2.m_group_last), 64'd1);
        end
      end
    end
  end

  initial begin
    int k;
    reset                 = 1'b1;
    reset2                = 1'b1;
    bus.s_write_req       = '0;
    bus.s_write_data      = '0;
    bus.m_write_ready     = 1'b0;
    bus2.s_write_req      = '0;
    bus2.s_write_data     = {8'h22, 8'h11, 8'h00};
    bus2.m_write_ready    = 1'b0;

    // Reset state.
    step(1'b1);
    step(1'b1);
    check_reset_outputs("reset");

    // Single requester, 4 beats: one arbitration cycle then back-to-back beats.
    step(1'b0);
    load(2, 4);
    drain("single_req", 20);

    // All four requesting: groups in owner order with no bubbles.
    step(1'b1);
    for (int i = 0; i < N; i++) load(i, 4);
    drain("all_req", 40);

    // Owner drops its request mid-group; the waiting requester stays stalled.
    step(1'b1);
    load(1, 2);
    load(3, 2);
    k = 0;
    while (!(m_holder == 1 && m_done == 1) && k < 10) begin
      step(1'b0);
      k++;
    end
    if (k == 10) bound_fail("drop_setup");
    en_off[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1'b0);
      @(negedge clk);
      check("drop_ready3", 64'(bus.s_write_ready[3]), 64'd0);
      check("drop_owner",  64'(bus.m_owner), 64'd1);
      check("drop_mreq",   64'(bus.m_write_req), 64'd0);
    end
    en_off = '0;
    drain("drop_resume", 20);

    // Packer stalls for 5 cycles mid-group.
    step(1'b1);
    load(0, 4);
    k = 0;
    while (!(m_holder == 0 && m_done == 1) && k < 10) begin
      step(1'b0);
      k++;
    end
    if (k == 10) bound_fail("stall_setup");
    ready_low = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(1'b0);
      @(negedge clk);
      check("stall_sready", 64'(bus.s_write_ready), 64'd0);
      check("stall_owner",  64'(bus.m_owner), 64'd0);
      check("stall_last",   64'(bus.m_group_last), 64'd1);
      check("stall_mreq",   64'(bus.m_write_req), 64'd1);
    end
    ready_low = 1'b0;
    drain("stall_resume", 20);

    // Reset after the first beat of a group, then a fresh group from requester 2.
    step(1'b1);
    load(0, 2);
    load(2, 2);
    k = 0;
    while (!(m_holder == 0 && m_done == 1) && k < 10) begin
      step(1'b0);
      k++;
    end
    if (k == 10) bound_fail("midreset_setup");
    step(1'b1);
    step(1'b0);
    check_reset_outputs("midreset");
    load(2, 2);
    drain("after_reset", 20);

    // Randomised traffic with gappy producers and a bursty packer.
    step(1'b1);
    en_pct  = 75;
    rdy_pct = 70;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() < 2) load(i, $urandom_range(1, 3));
      end
      step(1'b0);
    end
    en_pct  = 100;
    rdy_pct = 100;
    step(1'b1);
    step(1'b0);

    // Three requesters, one beat per group: owner rotates every beat.
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    bus2.s_write_req   = 3'b111;
    bus2.m_write_ready = 1'b1;
    for (int b = 0; b < 7; b++) exp2_q.push_back(b % N2);
    repeat (8) @(posedge clk);
    #1;
    bus2.s_write_req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("scoreboard_empty",  64'(exp_q.size()), 64'd0);
    check("scoreboard2_empty", 64'(exp2_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
